cache_refill: RTL and testbench

- Line-fill engine on the cache miss path. It is the read-side sibling of the dirty-line writeback stage and shares the same tag-lookup outputs.
- On a lookup miss it issues one AXI INCR read burst for the whole line and packs the returned beats into a line buffer.
- It then presents the completed line, with its tag and index, to the data/tag SRAM write port.
- Writeback and refill are independent: the victim and fill addresses differ, so no ordering between them is enforced here.

---
 rtl/cache_refill.sv | 132 +++++++++++++
 tb/tb_cache_refill.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill.sv
// Cache line-fill engine: issues one AXI INCR read burst per miss, packs the
// returned beats into a line buffer and offers the line to the SRAM write port.
module cache_refill #(
  parameter int         TAG_W    = 20,
  parameter int         INDEX_W  = 7,
  parameter int         OFFSET_W = 3,
  parameter int         BEAT_W   = 32,
  parameter int         ADDR_W   = 32,
  parameter logic [3:0] RF_ID    = 4'h1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         info_rsp,
  input  logic                         info_miss,
  input  logic [TAG_W-1:0]             info_tag,
  input  logic [INDEX_W-1:0]           core_index,
  output logic                         rf_busy,
  output logic                         rf_valid,
  input  logic                         rf_ready,
  output logic [(BEAT_W<<OFFSET_W)-1:0] rf_data,
  output logic [TAG_W-1:0]             rf_tag,
  output logic [INDEX_W-1:0]           rf_index,
  output logic                         rf_err,
  output logic [3:0]                   rf_arid,
  output logic [ADDR_W-1:0]            rf_araddr,
  output logic [7:0]                   rf_arlen,
  output logic [2:0]                   rf_arsize,
  output logic [1:0]                   rf_arburst,
  output logic                         rf_arvalid,
  input  logic                         rf_arready,
  input  logic [3:0]                   rf_rid,
  input  logic [BEAT_W-1:0]            rf_rdata,
  input  logic [1:0]                   rf_rresp,
  input  logic                         rf_rlast,
  input  logic                         rf_rvalid,
  output logic                         rf_rready
);

  localparam int BEATS  = 1 << OFFSET_W;
  localparam int BYTE_W = $clog2(BEAT_W / 8);
  localparam int LOW_W  = OFFSET_W + BYTE_W;
  localparam logic [OFFSET_W-1:0] LAST_SLOT = {OFFSET_W{1'b1}};

  typedef enum logic [1:0] {IDLE, AR, RECV, DONE} state_t;

  state_t               state_reg, state_next;
  logic [TAG_W-1:0]     tag_reg;
  logic [INDEX_W-1:0]   index_reg;
  logic [ADDR_W-1:0]    araddr_reg;
  logic [OFFSET_W-1:0]  count_reg;
  logic                 err_reg;
  logic                 accept_req;
  logic                 beat_fire;

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept_req = 1'b0;
    rf_arvalid = 1'b0;
    rf_rready  = 1'b0;
    rf_valid   = 1'b0;
    rf_busy    = (state_reg != IDLE);
    // Beats tagged with another master's ID are invisible to the fill.
    beat_fire  = (state_reg == RECV) && rf_rvalid && (rf_rid == RF_ID);
    case (state_reg)
      IDLE: begin
        if (info_rsp && info_miss) begin
          accept_req = 1'b1;
          state_next = AR;
        end
      end
      AR: begin
        rf_arvalid = 1'b1;
        if (rf_arready) state_next = RECV;
      end
      RECV: begin
        rf_rready = 1'b1;
        if (beat_fire && (rf_rlast || count_reg == LAST_SLOT)) state_next = DONE;
      end
      DONE: begin
        rf_valid = 1'b1;
        if (rf_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_reg    <= '0;
      index_reg  <= '0;
      araddr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (accept_req) begin
      tag_reg    <= info_tag;
      index_reg  <= core_index;
      araddr_reg <= ADDR_W'({info_tag, core_index, {LOW_W{1'b0}}});
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (beat_fire) begin
      count_reg <= count_reg + OFFSET_W'(1);
      // rlast must coincide exactly with the final slot; either mismatch flags the line.
      err_reg   <= err_reg | (rf_rresp != 2'b00) |
                   (rf_rlast && (count_reg != LAST_SLOT)) |
                   (!rf_rlast && (count_reg == LAST_SLOT));
    end
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
    logic [BEAT_W-1:0] slot_reg;
    always_ff @(posedge clk) begin
      if (!reset)                                         slot_reg <= '0;
      else if (beat_fire && count_reg == OFFSET_W'(gi))   slot_reg <= rf_rdata;
    end
    assign rf_data[gi*BEAT_W +: BEAT_W] = slot_reg;
  end

  assign rf_tag     = tag_reg;
  assign rf_index   = index_reg;
  assign rf_err     = err_reg;
  assign rf_araddr  = araddr_reg;
  assign rf_arid    = RF_ID;
  assign rf_arlen   = 8'(BEATS - 1);
  assign rf_arsize  = 3'(BYTE_W);
  assign rf_arburst = 2'b01;

endmodule

// File: tb/tb_cache_refill.sv
// Bench for cache_refill: scripted AXI read slave, directed vector table,
// hand-written reset/hit sequences and randomized fills against a line model.
module tb_cache_refill;

  localparam int BEATS   = 8;
  localparam int CFG_MAX = 24;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         info_rsp = 1'b0, info_miss = 1'b0;
  logic [19:0]  info_tag = '0;
  logic [6:0]   core_index = '0;
  logic         rf_busy, rf_valid, rf_err, rf_arvalid, rf_rready;
  logic         rf_ready = 1'b0;
  logic [255:0] rf_data;
  logic [19:0]  rf_tag;
  logic [6:0]   rf_index;
  logic [3:0]   rf_arid;
  logic [31:0]  rf_araddr;
  logic [7:0]   rf_arlen;
  logic [2:0]   rf_arsize;
  logic [1:0]   rf_arburst;
  logic         rf_arready = 1'b0;
  logic [3:0]   rf_rid = '0;
  logic [31:0]  rf_rdata = '0;
  logic [1:0]   rf_rresp = '0;
  logic         rf_rlast = 1'b0, rf_rvalid = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cache_refill #(.TAG_W(20), .INDEX_W(7), .OFFSET_W(3), .BEAT_W(32), .ADDR_W(32), .RF_ID(4'h1)) dut (
    .clk(clk), .reset(reset), .info_rsp(info_rsp), .info_miss(info_miss),
    .info_tag(info_tag), .core_index(core_index), .rf_busy(rf_busy),
    .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_data(rf_data), .rf_tag(rf_tag),
    .rf_index(rf_index), .rf_err(rf_err), .rf_arid(rf_arid), .rf_araddr(rf_araddr),
    .rf_arlen(rf_arlen), .rf_arsize(rf_arsize), .rf_arburst(rf_arburst),
    .rf_arvalid(rf_arvalid), .rf_arready(rf_arready), .rf_rid(rf_rid),
    .rf_rdata(rf_rdata), .rf_rresp(rf_rresp), .rf_rlast(rf_rlast),
    .rf_rvalid(rf_rvalid), .rf_rready(rf_rready)
  );

  // Scripted R channel: one entry per beat the slave will present, in order.
  logic [31:0] cfg_data [CFG_MAX];
  logic [1:0]  cfg_resp [CFG_MAX];
  bit          cfg_last [CFG_MAX];
  logic [3:0]  cfg_id   [CFG_MAX];
  int          cfg_gap  [CFG_MAX];
  int          cfg_n = 0;
  int          cfg_ar_delay = 0;

  logic [31:0] model_line [BEATS];

  logic ar_fire_q = 1'b0, r_fire_q = 1'b0;
  int   ar_count = 0, own_count = 0;

  always @(posedge clk) begin
    ar_fire_q <= rf_arvalid && rf_arready;
    r_fire_q  <= rf_rvalid && rf_rready;
    if (reset && rf_arvalid && rf_arready) ar_count <= ar_count + 1;
    if (reset && rf_rvalid && rf_rready && rf_rid == 4'h1) own_count <= own_count + 1;
  end

  int s_idx = 0, s_gap = 0, s_hold = 0;
  bit s_active = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      s_active = 1'b0; rf_rvalid = 1'b0; rf_arready = 1'b0; s_hold = cfg_ar_delay;
    end else begin
      if (rf_arvalid) begin
        if (s_hold == 0) rf_arready = 1'b1;
        else begin rf_arready = 1'b0; s_hold--; end
      end else begin
        rf_arready = 1'b0; s_hold = cfg_ar_delay;
      end
      if (ar_fire_q) begin
        s_active = 1'b1; s_idx = 0; s_gap = cfg_gap[0];
      end else if (r_fire_q && s_active) begin
        s_idx++;
        s_gap = (s_idx < cfg_n) ? cfg_gap[s_idx] : 0;
      end
      if (s_active && s_idx < cfg_n) begin
        if (s_gap > 0) begin
          rf_rvalid = 1'b0; s_gap--;
        end else begin
          rf_rvalid = 1'b1; rf_rdata = cfg_data[s_idx]; rf_rresp = cfg_resp[s_idx];
          rf_rlast = cfg_last[s_idx]; rf_rid = cfg_id[s_idx];
        end
      end else begin
        rf_rvalid = 1'b0; s_active = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r, input bit l,
                      input logic [3:0] id, input int g);
    cfg_data[cfg_n] = d; cfg_resp[cfg_n] = r; cfg_last[cfg_n] = l;
    cfg_id[cfg_n] = id; cfg_gap[cfg_n] = g;
    cfg_n++;
  endtask

  // Line model: own-ID beats fill slots in order; the burst ends at the first
  // own rlast or the eighth own beat, and rlast must land on exactly the eighth.
  task automatic model_fill(output logic err, output int nacc);
    int k;
    err = 1'b0; k = 0;
    for (int i = 0; i < cfg_n; i++) begin
      if (cfg_id[i] == 4'h1) begin
        model_line[k] = cfg_data[i];
        if (cfg_resp[i] != 2'b00) err = 1'b1;
        k++;
        if (cfg_last[i] || k == BEATS) begin
          if (cfg_last[i] != (k == BEATS)) err = 1'b1;
          break;
        end
      end
    end
    nacc = k;
  endtask

  task automatic build_dir(input int n_own, input int err_beat, input int last_beat,
                           input int foreign_after, input int gaps, input int ar_delay,
                           input logic [31:0] base);
    cfg_n = 0; cfg_ar_delay = ar_delay;
    for (int k = 0; k < n_own; k++) begin
      push(base + 32'(k), (k == err_beat) ? 2'b10 : 2'b00, k == last_beat, 4'h1, (k > 0) ? gaps : 0);
      if (k == foreign_after) push(32'hDEAD0000 + 32'(k), 2'b00, 1'b0, 4'h2, 0);
    end
  endtask

  task automatic build_random();
    int sel, lastk, n_own;
    sel   = $urandom_range(0, 11);
    lastk = (sel <= 7) ? sel : ((sel == 8) ? -1 : 7);
    n_own = (lastk < 0) ? 9 : 8;
    cfg_n = 0; cfg_ar_delay = $urandom_range(0, 3);
    for (int k = 0; k < n_own; k++) begin
      if ($urandom_range(0, 4) == 0)
        push($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(2, 15)), $urandom_range(0, 1));
      push($urandom, ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
           k == lastk, 4'h1, $urandom_range(0, 2));
    end
  endtask

  task automatic run_txn(input string name, input logic [19:0] tag, input logic [6:0] idx,
                         input int ready_delay, input bit late_miss, input bit recv_miss,
                         input int exp_lat, input logic exp_err, input int exp_beats,
                         output logic [255:0] got_line);
    logic [255:0] exp_line;
    logic [31:0]  exp_addr;
    logic         m_err;
    int           m_n, ar0, own0, cyc;
    bit           busy_ok, addr_ok, attr_ok, seen_ar, hold_ok, sent_recv;
    model_fill(m_err, m_n);
    for (int k = 0; k < BEATS; k++) exp_line[k*32 +: 32] = model_line[k];
    exp_addr = {tag, idx, 5'b0};
    @(negedge clk);
    ar0 = ar_count; own0 = own_count;
    busy_ok = 1; addr_ok = 1; attr_ok = 1; seen_ar = 0; sent_recv = 0;
    info_rsp = 1'b1; info_miss = 1'b1; info_tag = tag; core_index = idx;
    @(negedge clk);
    cyc = 1;
    info_rsp = 1'b0; info_miss = 1'b0;
    while (!rf_valid && cyc < 400) begin
      if (!rf_busy) busy_ok = 0;
      if (rf_arvalid) begin
        seen_ar = 1;
        if (rf_araddr !== exp_addr) addr_ok = 0;
        if (rf_arlen !== 8'd7 || rf_arsize !== 3'd2 || rf_arburst !== 2'b01 || rf_arid !== 4'h1)
          attr_ok = 0;
      end
      if (recv_miss && !sent_recv && rf_rready) begin
        info_rsp = 1'b1; info_miss = 1'b1; info_tag = ~tag; core_index = ~idx; sent_recv = 1;
      end else begin
        info_rsp = 1'b0; info_miss = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    info_rsp = 1'b0; info_miss = 1'b0;
    if (!rf_busy) busy_ok = 0;
    check({name, "_valid"}, rf_valid, 1'b1);
    if (exp_lat >= 0) check({name, "_latency"}, cyc, exp_lat);
    check({name, "_araddr"}, {seen_ar, addr_ok}, 2'b11);
    check({name, "_ar_attrs"}, seen_ar && attr_ok, 1'b1);
    check({name, "_busy"}, busy_ok, 1'b1);
    check({name, "_data"}, rf_data, exp_line);
    check({name, "_tag"}, rf_tag, tag);
    check({name, "_index"}, rf_index, idx);
    check({name, "_err"}, rf_err, exp_err);
    check({name, "_beats"}, own_count - own0, exp_beats);
    got_line = rf_data;
    hold_ok = 1;
    for (int i = 0; i < ready_delay; i++) begin
      @(negedge clk);
      if (rf_valid !== 1'b1 || rf_data !== exp_line || rf_err !== exp_err || rf_tag !== tag)
        hold_ok = 0;
    end
    if (ready_delay > 0) check({name, "_hold"}, hold_ok, 1'b1);
    rf_ready = 1'b1;
    if (late_miss) begin
      info_rsp = 1'b1; info_miss = 1'b1; info_tag = tag ^ 20'h1;
    end
    @(negedge clk);
    rf_ready = 1'b0; info_rsp = 1'b0; info_miss = 1'b0;
    check({name, "_idle_after"}, {rf_busy, rf_valid}, 2'b00);
    @(negedge clk);
    check({name, "_one_ar"}, ar_count - ar0, 1);
    $display("[TB] txn %s tag=%h index=%h err=%0b beats=%0d cycles=%0d",
             name, tag, idx, rf_err, own_count - own0, cyc);
  endtask

  typedef struct {
    string      name;
    logic [19:0] tag;
    logic [6:0]  idx;
    int         n_own, err_beat, last_beat, foreign_after, gaps, ar_delay, ready_delay;
    bit         late_miss, recv_miss;
    int         exp_lat;
    logic       exp_err;
    int         exp_beats;
  } vec_t;

  vec_t vecs [7];

  task automatic check_reset_state(input string name);
    check({name, "_ctrl"}, {rf_arvalid, rf_rready, rf_valid, rf_err, rf_busy}, 5'b0);
    check({name, "_araddr"}, rf_araddr, 32'h0);
    check({name, "_tag_index"}, {rf_tag, rf_index}, 27'h0);
    check({name, "_data"}, rf_data, 256'h0);
  endtask

  initial begin
    logic [255:0] line;
    logic         m_err;
    int           m_n, a0, o0, cyc;
    logic [19:0]  rtag;
    logic [6:0]   ridx;

    //        name        tag       idx    n  errb last for gap ard rdy late recv lat err beats
    vecs[0] = '{"basic",   20'hABCDE, 7'h15, 8, -1,  7,  -1, 0,  0,  0,  0,   0,   10, 1'b0, 8};
    vecs[1] = '{"bp",      20'h12345, 7'h7F, 8, -1,  7,  -1, 1,  5,  3,  0,   0,   -1, 1'b0, 8};
    vecs[2] = '{"rresp",   20'h00001, 7'h00, 8,  3,  7,  -1, 0,  0,  0,  0,   0,   -1, 1'b1, 8};
    vecs[3] = '{"early",   20'hFFFFF, 7'h01, 8, -1,  5,  -1, 0,  0,  0,  0,   0,   -1, 1'b1, 6};
    vecs[4] = '{"nolast",  20'h5A5A5, 7'h2B, 9, -1, -1,  -1, 0,  0,  0,  0,   0,   -1, 1'b1, 8};
    vecs[5] = '{"foreign", 20'h0BEEF, 7'h40, 8, -1,  7,   2, 0,  0,  0,  0,   0,   -1, 1'b0, 8};
    vecs[6] = '{"busy",    20'h77777, 7'h33, 8, -1,  7,  -1, 1,  2,  1,  1,   1,   -1, 1'b0, 8};

    for (int k = 0; k < BEATS; k++) model_line[k] = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      build_dir(vecs[i].n_own, vecs[i].err_beat, vecs[i].last_beat, vecs[i].foreign_after,
                vecs[i].gaps, vecs[i].ar_delay, 32'h1000_0000 + 32'(i * 65536));
      run_txn(vecs[i].name, vecs[i].tag, vecs[i].idx, vecs[i].ready_delay, vecs[i].late_miss,
              vecs[i].recv_miss, vecs[i].exp_lat, vecs[i].exp_err, vecs[i].exp_beats, line);
      if (i == 0) begin
        check("basic_beat0", line[31:0], 32'h1000_0000);
        check("basic_beat7", line[255:224], 32'h1000_0007);
      end
    end

    // A hit in IDLE must not start anything.
    @(negedge clk);
    a0 = ar_count;
    info_rsp = 1'b1; info_miss = 1'b0; info_tag = 20'hCAFE1; core_index = 7'h11;
    @(negedge clk);
    info_rsp = 1'b0;
    check("hit_busy", rf_busy, 1'b0);
    repeat (3) @(negedge clk);
    check("hit_no_ar", ar_count - a0, 0);

    // Reset after beat 4, then a clean refill.
    build_dir(8, -1, 7, -1, 1, 0, 32'h2000_0000);
    @(negedge clk);
    o0 = own_count;
    info_rsp = 1'b1; info_miss = 1'b1; info_tag = 20'h13579; core_index = 7'h0C;
    @(negedge clk);
    info_rsp = 1'b0; info_miss = 1'b0;
    cyc = 0;
    while (own_count - o0 < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_beats", own_count - o0, 5);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("mid_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < BEATS; k++) model_line[k] = '0;
    build_dir(8, -1, 7, -1, 0, 1, 32'h3000_0000);
    run_txn("after_reset", 20'h2468A, 7'h55, 0, 0, 0, -1, 1'b0, 8, line);

    for (int t = 0; t < 25; t++) begin
      build_random();
      model_fill(m_err, m_n);
      rtag = 20'($urandom);
      ridx = 7'($urandom);
      run_txn($sformatf("rand%0d", t), rtag, ridx, $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, m_err, m_n, line);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
